// File: rtl/pio_cond_pkg.sv
// Shared constants and types for the PIO input conditioner.
`timescale 1ns/1ps
package pio_cond_pkg;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;  // 10 ms
  localparam int REPEAT_DELAY_DEF    = CLK_HZ / 2;    // 500 ms
  localparam int REPEAT_PERIOD_DEF   = CLK_HZ / 10;   // 100 ms

  // Idle levels: switches read 0, active-low keys read released (1).
  localparam logic SW_RESET_VAL  = 1'b0;
  localparam logic KEY_RESET_VAL = 1'b1;

  typedef enum logic {
    REP_DELAY  = 1'b0,
    REP_PERIOD = 1'b1
  } rep_phase_e;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchroniser, debounce counter and stable register,
// with one-cycle rose/fell strobes coincident with the level update.
`timescale 1ns/1ps
module debounce_bit
  import pio_cond_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic RESET_VAL       = 1'b0,
  parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rose,
  output logic o_fell
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_st;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rose;
  logic             r_fell;

  logic w_diff;
  logic w_load;

  assign w_diff = r_sync2 ^ r_st;
  assign w_load = w_diff && (r_cnt == CNT_LAST);

  // NOTE: non-blocking assignments let every flop sample pre-edge values;
  // with blocking ones the chain would collapse into a single stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= RESET_VAL;
      r_cnt  <= '0;
      r_rose <= 1'b0;
      r_fell <= 1'b0;
    end else begin
      r_rose <= w_load & r_sync2;
      r_fell <= w_load & ~r_sync2;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_load) begin
        r_st  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_st;
  assign o_rose  = r_rose;
  assign o_fell  = r_fell;

endmodule

// File: rtl/pio_input_conditioner.sv
// Debounced switch/key front end for the NIOS II PIO inputs.
// Optional key auto-repeat is built when KEY_HOLD_REPEAT_EN is defined.
`timescale 1ns/1ps
module pio_input_conditioner
  import pio_cond_pkg::*;
#(
  parameter int N_SW            = 8,
  parameter int N_KEY           = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_KEY-1:0] key_raw_n,
  output logic [N_SW-1:0]  sw_clean,
  output logic [N_KEY-1:0] key_clean_n,
  output logic [N_KEY-1:0] key_press,
  output logic             sw_changed
);

  localparam int N_IN = N_SW + N_KEY;

  logic [N_IN-1:0]  w_raw;
  logic [N_IN-1:0]  w_level;
  logic [N_IN-1:0]  w_rose;
  logic [N_IN-1:0]  w_fell;
  logic [N_KEY-1:0] w_key_rose;
  logic [N_KEY-1:0] w_key_fell;

  assign w_raw = {key_raw_n, sw_raw};

  for (genvar g = 0; g < N_IN; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       ((g < N_SW) ? SW_RESET_VAL : KEY_RESET_VAL),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk     (clk_clk),
      .rst     (reset_reset),
      .i_raw   (w_raw[g]),
      .o_level (w_level[g]),
      .o_rose  (w_rose[g]),
      .o_fell  (w_fell[g])
    );
  end

  assign sw_clean    = w_level[N_SW-1:0];
  assign key_clean_n = w_level[N_IN-1:N_SW];
  assign w_key_rose  = w_rose[N_IN-1:N_SW];
  assign w_key_fell  = w_fell[N_IN-1:N_SW];

  // Strobes are flops updated with the level, so this OR is one clean pulse
  // even when several switches settle on the same edge.
  assign sw_changed = |(w_rose[N_SW-1:0] | w_fell[N_SW-1:0]);

`ifdef KEY_HOLD_REPEAT_EN
  localparam int RCNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W   = $clog2(RCNT_MAX + 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  logic [N_KEY-1:0] w_rep_pulse;

  for (genvar k = 0; k < N_KEY; k++) begin : g_rep
    logic [RCNT_W-1:0] r_rcnt;
    rep_phase_e        r_phase;
    logic              r_pulse;
    logic              w_due;

    assign w_due = (r_phase == REP_DELAY) ? (r_rcnt == DELAY_LAST)
                                          : (r_rcnt == PERIOD_LAST);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
        r_rcnt  <= '0;
        r_phase <= REP_DELAY;
        r_pulse <= 1'b0;
      end else if (key_clean_n[k]) begin
        r_rcnt  <= '0;
        r_phase <= REP_DELAY;
        r_pulse <= 1'b0;
      end else if (w_due) begin
        r_rcnt  <= '0;
        r_phase <= REP_PERIOD;
        r_pulse <= 1'b1;
      end else begin
        r_rcnt  <= r_rcnt + 1'b1;
        r_pulse <= 1'b0;
      end
    end

    assign w_rep_pulse[k] = r_pulse;
  end

  // A repeat falling due on the release edge is masked by that edge's rose strobe.
  assign key_press = w_key_fell | (w_rep_pulse & ~w_key_rose);
`else
  logic        w_unused_key_rose;
  logic [31:0] w_unused_repeat_cfg;

  assign w_unused_key_rose   = |w_key_rose;
  assign w_unused_repeat_cfg = 32'(REPEAT_DELAY ^ REPEAT_PERIOD);
  assign key_press           = w_key_fell;
`endif

endmodule

// File: doc/pio_input_conditioner.md
Name: pio_input_conditioner

Overview:
- Front-end stage feeding the NIOS II SoC's PIO inputs: sw_wire_export[7:0], key0_wire_export and key1_wire_export.
- Synchronises the raw DE-board slide switches and push-buttons into the clk_clk domain and debounces every bit.
- Presents clean levels to the PIO ports, plus single-cycle key-press and switch-change pulses for top-level logic.
- Raw KEY pins are active-low. Key outputs stay active-low so the software-visible PIO semantics do not change.

Parameters:
- N_SW, 8, number of slide-switch bits.
- N_KEY, 2, number of push-buttons.
- DEBOUNCE_CYCLES, 500000, cycles an input must be stable before it is accepted (10 ms at 50 MHz). Minimum value is 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived).
- REPEAT_DELAY, 25000000, hold time before the first auto-repeat pulse (only used with KEY_HOLD_REPEAT_EN).
- REPEAT_PERIOD, 5000000, interval between subsequent auto-repeat pulses (only used with KEY_HOLD_REPEAT_EN).

Ports:
- clk_clk  in  1  system clock, 50 MHz; the same clock that drives the SoC.
- reset_reset  in  1  asynchronous, active-high reset.
- sw_raw  in  N_SW  raw slide switches, asynchronous.
- key_raw_n  in  N_KEY  raw push-buttons, active-low, asynchronous.
- sw_clean  out  N_SW  debounced switches; drives sw_wire_export.
- key_clean_n  out  N_KEY  debounced keys, active-low; bit0 drives key0_wire_export, bit1 drives key1_wire_export.
- key_press  out  N_KEY  one-cycle pulse per accepted press.
- sw_changed  out  1  one-cycle pulse when any sw_clean bit updates.

Behaviour:
- Single clock domain. All flops use asynchronous, active-high reset.
- Reset values:
  - Synchroniser stages: sw 0, key 1.
  - sw_clean = 0, key_clean_n = all 1s.
  - key_press = 0, sw_changed = 0.
  - All counters = 0.
  - Asserting reset mid-debounce or mid-repeat discards all progress. No pulse is generated on reset release.
- Synchroniser: 2-flop chain per bit; sync2 is the only value the debounce logic sees.
- Debounce, per bit, with independent counter cnt[CNT_W-1:0] and stable register st:
  - sync2 == st: cnt <= 0.
  - sync2 != st and cnt == DEBOUNCE_CYCLES-1: st <= sync2, cnt <= 0.
  - sync2 != st otherwise: cnt <= cnt+1.
- Latency: if the first edge to sample a new clean level into sync1 is edge 1, st updates at edge DEBOUNCE_CYCLES+2.
- Glitch rejection: any excursion shorter than DEBOUNCE_CYCLES sampled cycles is rejected, and its cnt restarts from 0 on return.
- Counter bound: cnt never exceeds DEBOUNCE_CYCLES-1, so no wrap.
- key_press[i]:
  - Registered; high for exactly the one cycle in which key_clean_n[i] first reads 0, i.e. updated at the same edge as the 1->0 transition.
  - Release (0->1) produces no pulse.
- sw_changed: registered OR of per-bit st updates. High for one cycle coincident with the new sw_clean value. Simultaneous multi-bit updates still give a single one-cycle pulse.
- Keys are independent: simultaneous presses give simultaneous pulses.
- sw_clean and key_clean_n are direct register outputs with no combinational path from the inputs.

Optional Feature:
- Macro: KEY_HOLD_REPEAT_EN.
- Defined: each key gets a repeat counter rcnt, cleared whenever key_clean_n[i] == 1.
  - While the key is held low, the first extra key_press pulse fires REPEAT_DELAY cycles after the press pulse.
  - Further pulses follow every REPEAT_PERIOD cycles.
  - Release clears rcnt immediately. A pulse already due at the release edge is suppressed.
- Undefined: repeat logic is absent; exactly one key_press pulse per debounced press.

Decomposition:
- Package pio_cond_pkg holds:
  - default constants DEBOUNCE_CYCLES_DEF, REPEAT_DELAY_DEF, REPEAT_PERIOD_DEF;
  - CLK_HZ = 50000000;
  - the reset-value constants for the sw and key levels.
- Sub-module debounce_bit: single-bit 2-flop sync plus counter plus stable register.
  - Parameterised by DEBOUNCE_CYCLES and RESET_VAL.
  - Outputs the level and a one-cycle "rose"/"fell" strobe.
  - Top level instantiates it N_SW+N_KEY times via generate, then adds the pulse and repeat logic.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset check: hold reset_reset high with key_raw_n=2'b00 and sw_raw=8'hFF -> sw_clean=0, key_clean_n=2'b11, no pulses. Release reset with inputs stable -> sw_clean=8'hFF at edge 6, with one sw_changed pulse.
- Clean press: drop key_raw_n[0] to 0 and hold -> key_clean_n[0]=0 at edge 6 after first sampling, with key_press[0] high for exactly that cycle. Release -> key_clean_n[0]=1 after 6 edges, no pulse.
- Glitch rejection: key_raw_n[1] low for 3 cycles, then high, repeated 5 times -> key_clean_n[1] stays 1, key_press never asserts.
- Switch bounce: sw_raw toggles 8'h00/8'h5A every 2 cycles for 20 cycles, then settles at 8'h5A -> sw_clean=8'h5A exactly 6 edges after the last change, single sw_changed pulse.
- Simultaneous events: both keys pressed on the same cycle -> key_press=2'b11 for one cycle. Reset asserted 2 cycles into a debounce -> no update after release until a full new window elapses.
- KEY_HOLD_REPEAT_EN build: hold key0 low for 60 cycles -> press pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52. Without the macro -> only t0.
